// File: rtl/scanout_fetch.sv
// rtl/scanout_fetch.sv - frame scan-out read client feeding a first-word-fall-through pixel FIFO
//
// Fetches LINE_WORDS*LINES consecutive 32-bit words per frame from BASE_ADDR
// through a single-outstanding read port and buffers them for the pixel stage.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   frame_start       one-cycle pulse, (re)starts the frame fetch
//   mem_addr/mem_read read request to the memory controller (held until mem_ready)
//   mem_ready         one-cycle response strobe, mem_rddata valid with it
//   px_valid/px_data  FIFO head, popped on px_valid & px_ready
//   level             FIFO occupancy
//   underrun          sticky: consumer was ready on an empty FIFO mid-frame
//   frame_done        one-cycle pulse after the last word of the frame is pushed
//
// Optional build macro SCANOUT_UNDERRUN_CNT_EN adds underrun_count[15:0], a
// saturating count of underrun cycles cleared by rst or frame_start.
module scanout_fetch #(
  parameter logic [19:0] BASE_ADDR  = 20'h00000,
  parameter int          LINE_WORDS = 160,
  parameter int          LINES      = 120,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  output logic [19:0]                   mem_addr,
  output logic                          mem_read,
  input  logic                          mem_ready,
  input  logic [31:0]                   mem_rddata,
  output logic                          px_valid,
  output logic [31:0]                   px_data,
  input  logic                          px_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          underrun,
  output logic                          frame_done
`ifdef SCANOUT_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                   underrun_count
`endif
);

  localparam int              AW          = $clog2(FIFO_DEPTH);
  localparam int              LW          = AW + 1;
  localparam logic [19:0]     FRAME_WORDS = 20'(LINE_WORDS * LINES);
  localparam logic [LW-1:0]   DEPTH_L     = LW'(FIFO_DEPTH);
  localparam logic [AW-1:0]   PTR_ONE     = AW'(1);

  typedef enum logic [1:0] {IDLE, GAP, REQ, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [19:0]     addr_q, addr_d;
  logic [19:0]     words_left_q, words_left_d;
  logic [LW-1:0]   level_q, level_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            px_valid_q;
  logic [31:0]     px_data_q;
  logic            mem_read_q;
  logic            underrun_q;
  logic            frame_done_q;
  logic [31:0]     fifo_mem [FIFO_DEPTH];

  logic            reload;
  logic            push;
  logic            pop;
  logic            ur_cond;

  assign pop = px_ready & px_valid_q;
  // An empty FIFO with words still to fetch means the frame is active and starved.
  assign ur_cond = px_ready & ~px_valid_q & (words_left_q != 20'd0);

  always_comb begin
    state_d      = state_q;
    reload       = 1'b0;
    push         = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          reload  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (frame_start) begin
          reload  = 1'b1;
          state_d = GAP;
        end else if (words_left_q == 20'd0) begin
          state_d = IDLE;
        end else if ((level_q - LW'(pop)) < DEPTH_L) begin
          // Only request when the returning word is guaranteed a slot.
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_d = GAP;
          // A restart coinciding with the response discards the word.
          if (frame_start) reload = 1'b1;
          else             push   = 1'b1;
        end else if (frame_start) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // The outstanding read must complete before the port is reused.
        if (mem_ready) begin
          reload  = 1'b1;
          state_d = GAP;
        end
      end
      default: state_d = IDLE;
    endcase

    addr_d       = addr_q;
    words_left_d = words_left_q;
    if (reload) begin
      addr_d       = BASE_ADDR;
      words_left_d = FRAME_WORDS;
    end else if (push) begin
      addr_d       = addr_q + 20'd1;
      words_left_d = words_left_q - 20'd1;
    end

    if (reload) level_d = '0;
    else        level_d = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= BASE_ADDR;
      words_left_q <= '0;
      level_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      px_valid_q   <= 1'b0;
      px_data_q    <= '0;
      mem_read_q   <= 1'b0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      level_q      <= level_d;
      px_valid_q   <= (level_d != '0);
      mem_read_q   <= (state_d == REQ) || (state_d == FLUSH);
      frame_done_q <= push && (words_left_q == 20'd1);

      if (reload) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        // Head register: refill on pop, or take the incoming word when the
        // FIFO is (or is about to become) empty.
        if (pop) begin
          if (level_q > LW'(1)) px_data_q <= fifo_mem[rd_ptr_q + PTR_ONE];
          else if (push)        px_data_q <= mem_rddata;
        end else if (push && (level_q == '0)) begin
          px_data_q <= mem_rddata;
        end
      end

      if (frame_start || reload) underrun_q <= 1'b0;
      else if (ur_cond)          underrun_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_rddata;
  end

`ifdef SCANOUT_UNDERRUN_CNT_EN
  logic [15:0] ur_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      ur_cnt_q <= '0;
    end else if (ur_cond && (ur_cnt_q != 16'hFFFF)) begin
      ur_cnt_q <= ur_cnt_q + 16'd1;
    end
  end

  assign underrun_count = ur_cnt_q;
`endif

  assign mem_addr   = addr_q;
  assign mem_read   = mem_read_q;
  assign px_valid   = px_valid_q;
  assign px_data    = px_data_q;
  assign level      = level_q;
  assign underrun   = underrun_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scanout_fetch.sv
// tb/tb_scanout_fetch.sv - scoreboard bench for scanout_fetch
module tb_scanout_fetch;

  localparam logic [19:0] BASE  = 20'hFFFFE;
  localparam int          DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     frame_start;
  logic [19:0]              mem_addr;
  logic                     mem_read;
  logic                     mem_ready;
  logic [31:0]              mem_rddata;
  logic                     px_valid;
  logic [31:0]              px_data;
  logic                     px_ready;
  logic [$clog2(DEPTH):0]   level;
  logic                     underrun;
  logic                     frame_done;
`ifdef SCANOUT_UNDERRUN_CNT_EN
  logic [15:0]              underrun_count;
  int                       ucnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_addr[$];
  logic [31:0] exp_px[$];

  int   lat    = 1;
  int   n_req  = 0;
  int   n_done = 0;
  int   wcnt   = 0;
  logic follow  = 1'b0;
  logic ready_r = 1'b0;

  assign px_ready = follow ? px_valid : ready_r;

  scanout_fetch #(
    .BASE_ADDR (BASE),
    .LINE_WORDS(4),
    .LINES     (2),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_ready  (mem_ready),
    .mem_rddata (mem_rddata),
    .px_valid   (px_valid),
    .px_data    (px_data),
    .px_ready   (px_ready),
    .level      (level),
    .underrun   (underrun),
    .frame_done (frame_done)
`ifdef SCANOUT_UNDERRUN_CNT_EN
    ,
    .underrun_count(underrun_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // Memory model: answers a held read after lat cycles with data = addr + 1
  // and checks the requested address against the expected sequence.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      mem_ready = 1'b0;
      wcnt = 0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
    end else if (mem_read) begin
      if (wcnt >= lat) begin
        mem_ready  = 1'b1;
        mem_rddata = {12'h000, mem_addr} + 32'd1;
        wcnt = 0;
        n_req++;
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_addr: got %h expected no request", mem_addr);
        end else begin
          check("req_addr", {12'h000, mem_addr}, {12'h000, exp_addr.pop_front()});
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Pixel monitor: every pop is compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && px_valid && px_ready) begin
      if (exp_px.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL px_data: got %h expected no pixel", px_data);
      end else begin
        check("px_data", px_data, exp_px.pop_front());
      end
    end
    if (frame_done) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_frame(input logic do_px);
    logic [19:0] a;
    a = BASE;
    for (int i = 0; i < 8; i++) begin
      exp_addr.push_back(a);
      if (do_px) exp_px.push_back({12'h000, a} + 32'd1);
      a = a + 20'd1;
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (exp_px.size() == 0 && level == '0 && !mem_read) break;
    end
    if (k == 400) timeout(name);
  endtask

  initial begin
    int k;
    int d0;
    int r0;
    rst = 1'b1;
    frame_start = 1'b0;
    mem_ready = 1'b0;
    mem_rddata = '0;
    tick(); tick(); tick();
    @(negedge clk);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_addr", mem_addr, BASE);
    check("rst_px_valid", px_valid, 0);
    check("rst_px_data", px_data, 0);
    check("rst_level", level, 0);
    check("rst_underrun", underrun, 0);
    check("rst_frame_done", frame_done, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    tick();

    // Full frame with address wrap FFFFE, FFFFF, 0 .. 5; consumer takes each word.
    lat = 2; follow = 1'b1;
    push_frame(1'b1);
    d0 = n_done;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    check("lat_gap_mem_read", mem_read, 0);
    @(negedge clk);
    check("lat_req_mem_read", mem_read, 1);
    check("lat_req_mem_addr", mem_addr, BASE);
    wait_drain("frame1_drain");
    tick(); tick();
    check("frame1_done_pulses", n_done - d0, 1);
    check("frame1_addr_left", exp_addr.size(), 0);
    check("frame1_underrun", underrun, 0);
    // Ready on an empty FIFO after completion is not an underrun.
    follow = 1'b0; ready_r = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    check("idle_ready_underrun", underrun, 0);
    ready_r = 1'b0;
    tick();

    // Back-pressure: no consumer, FIFO fills to DEPTH and requests stop.
    lat = 1;
    push_frame(1'b1);
    d0 = n_done;
    r0 = n_req;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    @(negedge clk);
    check("bp_reads", n_req - r0, 4);
    check("bp_level", level, 4);
    check("bp_mem_read", mem_read, 0);
    @(posedge clk); #2;
    ready_r = 1'b1;
    @(posedge clk); #2;
    ready_r = 1'b0;
    @(negedge clk);
    check("bp_pop_level", level, 3);
    check("bp_pop_mem_read", mem_read, 1);
    follow = 1'b1;
    wait_drain("bp_drain");
    tick();
    check("bp_done_pulses", n_done - d0, 1);
    check("bp_addr_left", exp_addr.size(), 0);

    // Restart while the read of word 3 (addr 0) is outstanding.
    lat = 6;
    exp_addr.push_back(20'hFFFFE);
    exp_addr.push_back(20'hFFFFF);
    exp_addr.push_back(20'h00000);
    exp_px.push_back(32'h000FFFFF);
    exp_px.push_back(32'h00100000);
    push_frame(1'b1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mem_read && mem_addr == 20'h00000) break;
    end
    if (k == 100) timeout("restart_wait_addr0");
    @(posedge clk); #2;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    check("flush_mem_read", mem_read, 1);
    check("flush_mem_addr", mem_addr, 20'h00000);
    for (k = 0; k < 50; k++) begin
      if (!mem_read) break;
      @(negedge clk);
    end
    if (k == 50) timeout("flush_release");
    check("flush_level_gap", level, 0);
    for (k = 0; k < 50; k++) begin
      if (mem_read) break;
      @(negedge clk);
    end
    if (k == 50) timeout("flush_rerequest");
    check("restart_mem_addr", mem_addr, BASE);
    check("restart_level", level, 0);
    wait_drain("restart_drain");
    tick();
    check("restart_addr_left", exp_addr.size(), 0);

    // Underrun: consumer ready from frame_start on, slow controller.
    lat = 20; follow = 1'b0;
    push_frame(1'b1);
    frame_start = 1'b1;
    ready_r = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
`ifdef SCANOUT_UNDERRUN_CNT_EN
    ucnt = (px_ready && !px_valid) ? 1 : 0;
`endif
    @(negedge clk);
    check("underrun_set", underrun, 1);
`ifdef SCANOUT_UNDERRUN_CNT_EN
    if (px_ready && !px_valid) ucnt++;
`endif
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (frame_done) break;
`ifdef SCANOUT_UNDERRUN_CNT_EN
      if (px_ready && !px_valid) ucnt++;
`endif
    end
    if (k == 400) timeout("underrun_frame_done");
`ifdef SCANOUT_UNDERRUN_CNT_EN
    check("underrun_count", underrun_count, ucnt);
`endif
    wait_drain("underrun_drain");
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    check("underrun_sticky", underrun, 1);
`ifdef SCANOUT_UNDERRUN_CNT_EN
    check("underrun_count_after", underrun_count, ucnt);
`endif

    // Next frame_start clears underrun; reset lands mid-request.
    @(posedge clk); #2;
    lat = 3;
    ready_r = 1'b0;
    push_frame(1'b0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    check("underrun_cleared", underrun, 0);
`ifdef SCANOUT_UNDERRUN_CNT_EN
    check("underrun_count_cleared", underrun_count, 0);
`endif
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mem_read && mem_addr == 20'hFFFFF) break;
    end
    if (k == 100) timeout("reset_wait_req");
    check("pre_reset_level", level, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_mem_read", mem_read, 0);
    check("midrst_level", level, 0);
    check("midrst_px_valid", px_valid, 0);
    check("midrst_mem_addr", mem_addr, BASE);
    exp_addr.delete();
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    check("post_rst_idle", mem_read, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
